// File: rtl/initiator_port.sv
// Initiator endpoint of the serial bus: serializes address/write data,
// collects read bytes, and bounds every wait with a timeout.
module initiator_port #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_req,
    input  logic [15:0] init_addr,
    input  logic [7:0]  init_wdata,
    input  logic        init_rw,
    output logic        init_busy,
    output logic        init_done,
    output logic        init_error,
    output logic [7:0]  init_rdata,
    output logic        init_rdata_valid,
    output logic        bus_data_out,
    output logic        bus_data_out_valid,
    output logic        bus_mode,
    output logic        bus_init_rw,
    input  logic        bus_data_in,
    input  logic        bus_data_in_valid,
    input  logic        bus_target_ready,
    input  logic        bus_target_ack
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_READY,
        ADDR,
        DATA,
        RX,
        WAIT_ACK,
        DONE
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [15:0]   addr_q;
    logic [7:0]    wdata_q;
    logic [7:0]    rx_q;
    logic          rw_q;
    logic [3:0]    acnt;
    logic [2:0]    bcnt;
    logic [TW-1:0] tcnt;
    logic          tout;

    assign tout = (tcnt == TLAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            addr_q             <= '0;
            wdata_q            <= '0;
            rx_q               <= '0;
            rw_q               <= 1'b0;
            acnt               <= '0;
            bcnt               <= '0;
            tcnt               <= '0;
            init_busy          <= 1'b0;
            init_done          <= 1'b0;
            init_error         <= 1'b0;
            init_rdata         <= '0;
            init_rdata_valid   <= 1'b0;
            bus_data_out       <= 1'b0;
            bus_data_out_valid <= 1'b0;
            bus_mode           <= 1'b0;
            bus_init_rw        <= 1'b0;
        end else begin
            init_done        <= 1'b0;
            init_error       <= 1'b0;
            init_rdata_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (init_req) begin
                        addr_q      <= init_addr;
                        wdata_q     <= init_wdata;
                        rw_q        <= init_rw;
                        bus_init_rw <= init_rw;
                        init_busy   <= 1'b1;
                        tcnt        <= '0;
                        state       <= WAIT_READY;
                    end
                end
                WAIT_READY: begin
                    if (bus_target_ready) begin
                        acnt               <= '0;
                        bus_data_out       <= addr_q[0];
                        bus_data_out_valid <= 1'b1;
                        bus_mode           <= 1'b0;
                        state              <= ADDR;
                    end else if (tout) begin
                        init_done  <= 1'b1;
                        init_error <= 1'b1;
                        state      <= DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ADDR: begin
                    if (acnt == 4'd15) begin
                        bcnt <= '0;
                        tcnt <= '0;
                        if (rw_q) begin
                            bus_data_out <= wdata_q[0];
                            bus_mode     <= 1'b1;
                            state        <= DATA;
                        end else begin
                            bus_data_out       <= 1'b0;
                            bus_data_out_valid <= 1'b0;
                            state              <= RX;
                        end
                    end else begin
                        acnt         <= acnt + 4'd1;
                        bus_data_out <= addr_q[acnt + 4'd1];
                    end
                end
                DATA: begin
                    if (bcnt == 3'd7) begin
                        tcnt               <= '0;
                        bus_data_out       <= 1'b0;
                        bus_data_out_valid <= 1'b0;
                        bus_mode           <= 1'b0;
                        state              <= WAIT_ACK;
                    end else begin
                        bcnt         <= bcnt + 3'd1;
                        bus_data_out <= wdata_q[bcnt + 3'd1];
                    end
                end
                WAIT_ACK: begin
                    if (bus_target_ack) begin
                        init_done <= 1'b1;
                        state     <= DONE;
                    end else if (tout) begin
                        init_done  <= 1'b1;
                        init_error <= 1'b1;
                        state      <= DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RX: begin
                    if (bus_data_in_valid) begin
                        rx_q[bcnt] <= bus_data_in;
                        tcnt       <= '0;
                        if (bcnt == 3'd7) begin
                            // top bit arrives this cycle, so merge it directly
                            init_rdata       <= {bus_data_in, rx_q[6:0]};
                            init_rdata_valid <= 1'b1;
                            init_done        <= 1'b1;
                            state            <= DONE;
                        end else begin
                            bcnt <= bcnt + 3'd1;
                        end
                    end else if (tout) begin
                        init_done  <= 1'b1;
                        init_error <= 1'b1;
                        state      <= DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DONE: begin
                    init_busy <= 1'b0;
                    acnt      <= '0;
                    bcnt      <= '0;
                    tcnt      <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_initiator_port.sv
// Randomized bench for initiator_port: per-cycle outputs checked
// against a transaction-level timing model.
module tb_initiator_port;

    localparam int T = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_req = 1'b0;
    logic [15:0] init_addr = '0;
    logic [7:0]  init_wdata = '0;
    logic        init_rw = 1'b0;
    logic        init_busy;
    logic        init_done;
    logic        init_error;
    logic [7:0]  init_rdata;
    logic        init_rdata_valid;
    logic        bus_data_out;
    logic        bus_data_out_valid;
    logic        bus_mode;
    logic        bus_init_rw;
    logic        bus_data_in = 1'b0;
    logic        bus_data_in_valid = 1'b0;
    logic        bus_target_ready = 1'b0;
    logic        bus_target_ack = 1'b0;

    always #5 clk = ~clk;

    initiator_port #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .init_req(init_req),
        .init_addr(init_addr),
        .init_wdata(init_wdata),
        .init_rw(init_rw),
        .init_busy(init_busy),
        .init_done(init_done),
        .init_error(init_error),
        .init_rdata(init_rdata),
        .init_rdata_valid(init_rdata_valid),
        .bus_data_out(bus_data_out),
        .bus_data_out_valid(bus_data_out_valid),
        .bus_mode(bus_mode),
        .bus_init_rw(bus_init_rw),
        .bus_data_in(bus_data_in),
        .bus_data_in_valid(bus_data_in_valid),
        .bus_target_ready(bus_target_ready),
        .bus_target_ack(bus_target_ack)
    );

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] m_rdata = '0;
    int         gap[8];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] obs();
        return {init_busy, init_done, init_error, init_rdata_valid,
                bus_data_out_valid, bus_mode, bus_data_out, bus_init_rw,
                init_rdata};
    endfunction

    // Edge n counts posedges after the one that samples init_req (n=0).
    // d: cycles ready stays low; a: ack delay (0 = tied high, <0 = never).
    task automatic run_txn(input logic [15:0] addr, input logic [7:0] wd,
                           input logic rw, input int d, input int a,
                           input logic [7:0] rb);
        int   A, W, R, D, t, m, hit;
        bit   err;
        int   bedge[8];
        logic v, md, b;
        logic [15:0] e;
        A = 1 + d;
        W = A + 24;
        R = A + 16;
        D = -1;
        err = 1'b0;
        for (int k = 0; k < 8; k++) bedge[k] = -1;
        if (d >= T) begin
            D = T;
            err = 1'b1;
        end else if (rw) begin
            if (a >= 0 && a < T) D = W + 1 + a;
            else begin
                D = W + T;
                err = 1'b1;
            end
        end else begin
            t = R;
            for (int k = 0; k < 8; k++) begin
                if (D < 0) begin
                    if (gap[k] >= T) begin
                        D = t + T;
                        err = 1'b1;
                    end else begin
                        t = t + gap[k] + 1;
                        bedge[k] = t;
                    end
                end
            end
            if (D < 0) D = t;
        end

        init_req   = 1'b1;
        init_addr  = addr;
        init_wdata = wd;
        init_rw    = rw;
        for (int n = 0; n <= D + 1; n++) begin
            @(negedge clk);
            if (n == D && !err && !rw) m_rdata = rb;
            v = 1'b0;
            md = 1'b0;
            b = 1'b0;
            if (d < T && n >= A && n <= A + 15) begin
                v = 1'b1;
                b = addr[n-A];
            end else if (d < T && rw && n >= A + 16 && n <= A + 23) begin
                v = 1'b1;
                md = 1'b1;
                b = wd[n-A-16];
            end
            e = {n <= D, n == D, n == D && err, n == D && !err && !rw,
                 v, md, b, rw, m_rdata};
            chk("cyc", {16'h0, obs()}, {16'h0, e});

            m = n + 1;
            init_req = ($urandom_range(0, 3) == 0) && (n <= D);
            if (init_req) begin
                init_addr  = 16'hFFFF;
                init_wdata = 8'($urandom);
                init_rw    = 1'($urandom);
            end
            if (d >= T || m <= A) bus_target_ready = (d < T && m >= A);
            else bus_target_ready = 1'($urandom);
            if (rw && a == 0) bus_target_ack = 1'b1;
            else if (rw && d < T && m >= W + 1)
                bus_target_ack = (a > 0 && m >= W + 1 + a);
            else bus_target_ack = 1'($urandom);
            hit = -1;
            for (int k = 0; k < 8; k++) if (bedge[k] == m) hit = k;
            bus_data_in = 1'($urandom);
            if (hit >= 0) begin
                bus_data_in_valid = 1'b1;
                bus_data_in = rb[hit];
            end else if (!rw && d < T && m > R && m <= D) begin
                bus_data_in_valid = 1'b0;
            end else begin
                bus_data_in_valid = 1'($urandom);
            end
        end
    endtask

    task automatic set_gaps(input int g);
        for (int k = 0; k < 8; k++) gap[k] = g;
    endtask

    initial begin
        #1;
        chk("rst_out", {16'h0, obs()}, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_hold", {16'h0, obs()}, 32'h0);
        rst_n = 1'b1;

        set_gaps(0);
        run_txn(16'hA5C3, 8'h5A, 1'b1, 0, 0, 8'h00);
        set_gaps(1);
        run_txn(16'h0010, 8'h00, 1'b0, 0, -1, 8'hC3);
        run_txn(16'h1234, 8'h9E, 1'b1, 10, 0, 8'h00);
        run_txn(16'h4321, 8'h77, 1'b1, 0, -1, 8'h00);
        set_gaps(0);
        gap[3] = 2;
        gap[4] = T;
        run_txn(16'hBEEF, 8'h00, 1'b0, 2, -1, 8'h3C);
        run_txn(16'h0F0F, 8'h11, 1'b1, T, 0, 8'h00);
        set_gaps(0);
        gap[0] = T - 1;
        run_txn(16'h8001, 8'h00, 1'b0, T - 1, -1, 8'h81);
        run_txn(16'h7FFE, 8'hA0, 1'b1, 3, T - 1, 8'h00);

        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 8; k++)
                gap[k] = ($urandom_range(0, 29) == 0) ? T : $urandom_range(0, 3);
            run_txn(16'($urandom), 8'($urandom), 1'($urandom),
                    ($urandom_range(0, 19) == 0) ? T : $urandom_range(0, 6),
                    ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 5),
                    8'($urandom));
        end

        // reset while address bit 7 is on the wire
        init_req = 1'b1;
        init_addr = 16'hA5C3;
        init_wdata = 8'h5A;
        init_rw = 1'b1;
        bus_target_ready = 1'b1;
        bus_target_ack = 1'b1;
        bus_data_in_valid = 1'b0;
        for (int n = 0; n <= 8; n++) begin
            @(negedge clk);
            init_req = 1'b0;
        end
        chk("pre_rst", {30'h0, bus_data_out_valid, bus_data_out}, 32'h3);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid", {16'h0, obs()}, 32'h0);
        m_rdata = 8'h00;
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_hold", {16'h0, obs()}, 32'h0);
        end
        rst_n = 1'b1;
        set_gaps(0);
        run_txn(16'h5AA5, 8'hC6, 1'b1, 1, 0, 8'h00);
        run_txn(16'h0001, 8'h00, 1'b0, 0, -1, 8'h96);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
